instr_loader: RTL and testbench



---
 rtl/instr_loader.sv | 162 ++++++++++++++++
 tb/tb_instr_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream loader for the 16-bit instruction memory: count byte, big-endian word pairs, one write strobe per word.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CSUM state).
module instr_loader #(
  parameter int MEM_DEPTH = 255,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] instruction_in,
  output logic [7:0]  instruction_add,
  output logic        write_enable,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        load_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CSUM, S_FINISH} state_t;
  localparam state_t S_END = S_CSUM;
`else
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_FINISH} state_t;
  localparam state_t S_END = S_FINISH;
`endif

  // Widest legal word count, kept at 9 bits so the compare against an 8-bit N never overflows.
  localparam logic [8:0] LIMIT = 9'(MEM_DEPTH - BASE_ADDR);
  localparam logic [7:0] BASE  = 8'(BASE_ADDR);

  state_t      state_reg, state_next;
  logic [7:0]  addr_reg;
  logic [7:0]  add_reg;
  logic [7:0]  word_cnt_reg;
  logic [7:0]  n_reg;
  logic [15:0] instr_reg;
  logic        busy_reg;
  logic        err_reg;
  logic        accept;
  logic        range_bad;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_reg;
`endif

  assign accept    = byte_valid && byte_ready;
  assign range_bad = {1'b0, byte_in} > LIMIT;

  always_comb begin
    state_next = state_reg;
    byte_ready = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_COUNT;
      end
      S_COUNT: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (byte_in == 8'd0 || range_bad) state_next = S_END;
          else                              state_next = S_HI;
        end
      end
      S_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_LO;
      end
      S_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (word_cnt_reg + 8'd1 == n_reg) state_next = S_END;
        else                              state_next = S_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_FINISH;
      end
`endif
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      addr_reg     <= BASE;
      add_reg      <= 8'd0;
      word_cnt_reg <= 8'd0;
      n_reg        <= 8'd0;
      instr_reg    <= 16'd0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg     <= 8'd0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            busy_reg     <= 1'b1;
            err_reg      <= 1'b0;
            addr_reg     <= BASE;
            word_cnt_reg <= 8'd0;
          end
        end
        S_COUNT: begin
          if (accept) begin
            n_reg <= byte_in;
            if (range_bad) err_reg <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_reg <= byte_in;
`endif
          end
        end
        S_HI: begin
          if (accept) begin
            instr_reg[15:8] <= byte_in;
`ifdef LOADER_CHECKSUM_EN
            csum_reg <= csum_reg ^ byte_in;
`endif
          end
        end
        S_LO: begin
          // Address is latched here so it is stable for the whole WRITE cycle and held afterwards.
          if (accept) begin
            instr_reg[7:0] <= byte_in;
            add_reg        <= addr_reg;
`ifdef LOADER_CHECKSUM_EN
            csum_reg <= csum_reg ^ byte_in;
`endif
          end
        end
        S_WRITE: begin
          addr_reg     <= addr_reg + 8'd1;
          word_cnt_reg <= word_cnt_reg + 8'd1;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept && byte_in != csum_reg) err_reg <= 1'b1;
        end
`endif
        S_FINISH: busy_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign instruction_in  = instr_reg;
  assign instruction_add = add_reg;
  assign write_enable    = (state_reg == S_WRITE);
  assign done            = (state_reg == S_FINISH);
  assign busy            = busy_reg;
  assign cpu_hold        = busy_reg;
  assign load_err        = err_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table-driven and random load sessions, plus reset and range corner cases.
`timescale 1ns/1ps
module tb_instr_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, write_enable, busy, cpu_hold, done, load_err;
  logic [15:0] instruction_in;
  logic [7:0]  instruction_add;

  logic        start_b = 1'b0;
  logic [7:0]  byte_b = 8'd0;
  logic        valid_b = 1'b0;
  logic        ready_b, we_b, busy_b, hold_b, done_b, err_b;
  logic [15:0] data_b;
  logic [7:0]  add_b;

  int n_cmp = 0;
  int n_bad = 0;

  instr_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .instruction_in(instruction_in), .instruction_add(instruction_add),
    .write_enable(write_enable), .busy(busy), .cpu_hold(cpu_hold), .done(done), .load_err(load_err)
  );

  instr_loader #(.MEM_DEPTH(255), .BASE_ADDR(10)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .byte_in(byte_b), .byte_valid(valid_b),
    .byte_ready(ready_b), .instruction_in(data_b), .instruction_add(add_b),
    .write_enable(we_b), .busy(busy_b), .cpu_hold(hold_b), .done(done_b), .load_err(err_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: stream = N, then hi/lo of each word; word i goes to address i, its strobe
  // in the cycle after its LO byte; done follows the last write (or the count / checksum byte).
  task automatic run_session(input logic [7:0] n, input logic [15:0] words[$], input int gap_max,
                             input bit junk, input bit bad_csum, output int nwr, output int last_addr);
    logic [7:0] stream[$];
    int nn;
    nn = int'(n);
    stream.push_back(n);
    for (int i = 0; i < nn; i++) begin
      stream.push_back(words[i][15:8]);
      stream.push_back(words[i][7:0]);
    end
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'd0;
      foreach (stream[i]) x = x ^ stream[i];
      stream.push_back(bad_csum ? ~x : x);
    end
`endif
    nwr = 0;
    last_addr = -1;
    @(negedge clk);
    start = 1'b1; byte_valid = junk; byte_in = 8'h03;
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0;
    chk("busy_start", busy, 1);
    chk("hold_start", cpu_hold, 1);
    chk("err_cleared", load_err, 0);
    for (int k = 0; k < stream.size(); k++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(negedge clk);
        chk("ready_gap", byte_ready, 1);
        chk("we_gap", write_enable, 0);
      end
      byte_valid = 1'b1; byte_in = stream[k];
      @(negedge clk);
      byte_valid = 1'b0;
      if (k >= 2 && k % 2 == 0 && k <= 2 * nn) begin
        chk("we", write_enable, 1);
        chk("addr", instruction_add, nwr);
        chk("data", instruction_in, words[nwr]);
        chk("ready_write", byte_ready, 0);
        last_addr = int'(instruction_add);
        if (junk) begin byte_valid = 1'b1; byte_in = 8'hA5; end
        nwr++;
        @(negedge clk);
        byte_valid = 1'b0;
      end
    end
    chk("done", done, 1);
    chk("we_fin", write_enable, 0);
    chk("ready_fin", byte_ready, 0);
    chk("err_fin", load_err, bad_csum);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_end", busy, 0);
    chk("hold_end", cpu_hold, 0);
    chk("err_sticky", load_err, bad_csum);
    $display("session n=%0d writes=%0d last_addr=%0d err=%0b", nn, nwr, last_addr, load_err);
  endtask

  typedef struct {
    logic [7:0]  n;
    logic [15:0] w0;
    logic [15:0] w1;
    int          gaps;
    bit          junk;
    int          exp_writes;
  } vec_t;

  vec_t tbl[5];
  logic [15:0] wq[$];
  int nwr, last;

  initial begin
    tbl[0] = '{8'd2, 16'h1234, 16'hABCD, 0, 1'b0, 2};
    tbl[1] = '{8'd0, 16'h0000, 16'h0000, 0, 1'b1, 0};
    tbl[2] = '{8'd1, 16'hFFFF, 16'h0000, 2, 1'b1, 1};
    tbl[3] = '{8'd2, 16'h0001, 16'h8000, 1, 1'b1, 2};
    tbl[4] = '{8'd1, 16'h5A5A, 16'h0000, 3, 1'b0, 1};

    #2;
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_add", instruction_add, 0);
    chk("rst_data", instruction_in, 0);
    chk("rst_add_b", add_b, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      wq = {};
      wq.push_back(tbl[t].w0);
      wq.push_back(tbl[t].w1);
      run_session(tbl[t].n, wq, tbl[t].gaps, tbl[t].junk, 1'b0, nwr, last);
      chk("nwrites", nwr, tbl[t].exp_writes);
    end

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(6, 1);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      run_session(8'(n), wq, 2, 1'($urandom), 1'b0, nwr, last);
      chk("nwrites_rand", nwr, n);
    end

    wq = {};
    for (int i = 0; i < 255; i++) wq.push_back(16'($urandom));
    run_session(8'hFF, wq, 0, 1'b0, 1'b0, nwr, last);
    chk("nwrites_full", nwr, 255);
    chk("last_addr_full", last, 254);

`ifdef LOADER_CHECKSUM_EN
    wq = {16'h1234};
    run_session(8'd1, wq, 1, 1'b1, 1'b0, nwr, last);
    run_session(8'd1, wq, 1, 1'b1, 1'b1, nwr, last);
`endif

    // Reset after the HI byte of word 1, then reload from address 0.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b1; byte_in = 8'd2;
    @(negedge clk);
    byte_in = 8'h12;
    @(negedge clk);
    byte_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", byte_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_add", instruction_add, 0);
    chk("mid_rst_data", instruction_in, 0);
    chk("mid_rst_we", write_enable, 0);
    @(negedge clk);
    reset = 1'b0;
    wq = {16'h5678, 16'h9ABC};
    run_session(8'd2, wq, 1, 1'b1, 1'b0, nwr, last);
    chk("reload_writes", nwr, 2);

    // BASE_ADDR=10: N=F6 exceeds the 245 legal words.
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; valid_b = 1'b1; byte_b = 8'hF6;
    @(negedge clk);
    valid_b = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk("b_csum_ready", ready_b, 1);
    valid_b = 1'b1; byte_b = 8'hF6;
    @(negedge clk);
    valid_b = 1'b0;
`endif
    chk("b_range_done", done_b, 1);
    chk("b_range_err", err_b, 1);
    chk("b_range_we", we_b, 0);
    @(negedge clk);
    chk("b_range_busy", busy_b, 0);
    chk("b_range_sticky", err_b, 1);
    $display("session base=10 n=246 err=%0b", err_b);

    // N=F5 is exactly the limit: accepted, first word lands at address 10.
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; valid_b = 1'b1; byte_b = 8'hF5;
    @(negedge clk);
    chk("b_limit_err", err_b, 0);
    chk("b_limit_ready", ready_b, 1);
    byte_b = 8'h11;
    @(negedge clk);
    byte_b = 8'h22;
    @(negedge clk);
    valid_b = 1'b0;
    chk("b_limit_we", we_b, 1);
    chk("b_limit_addr", add_b, 10);
    chk("b_limit_data", data_b, 16'h1122);
    $display("session base=10 n=245 first_addr=%0d", add_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
